// File: rtl/rob_completion_unit_pkg.sv
// Shared constants and types for the reorder-buffer completion unit.
// Completion-port slice offsets index the packed ROB_entries_in bus.
package rob_completion_unit_pkg;

  localparam int ROB_ENTRY_W = 5;
  localparam int PR_ADDR_W   = 5;
  localparam int ARCH_W      = 4;
  localparam int ROB_DEPTH   = 1 << ROB_ENTRY_W;
  localparam int NUM_CPL     = 3;

  localparam int CPL_ARITH = 2;
  localparam int CPL_MEM   = 1;
  localparam int CPL_TERM  = 0;

  localparam logic [ROB_ENTRY_W:0] FULL_COUNT = (ROB_ENTRY_W+1)'(ROB_DEPTH);

  typedef logic [ROB_ENTRY_W-1:0] rob_idx_t;

  typedef struct packed {
    logic                   is_term;
    logic [2*ARCH_W-1:0]    arch_dests;
    logic [2*PR_ADDR_W-1:0] phys_dests;
  } rob_payload_t;

  function automatic rob_idx_t cpl_slice(input logic [NUM_CPL*ROB_ENTRY_W-1:0] vec,
                                         input int port);
    return vec[port*ROB_ENTRY_W +: ROB_ENTRY_W];
  endfunction

endpackage

// File: rtl/rob_completion_unit_entry_array.sv
// Per-entry storage for the reorder buffer: valid/done flags plus payload,
// one allocate port, three completion ports, a retire port and a full flush.
module rob_entry_array
  import rob_completion_unit_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alloc_en,
  input  rob_idx_t                       alloc_idx,
  input  rob_payload_t                   alloc_data,
  input  logic [NUM_CPL-1:0]             cpl_en,
  input  logic [NUM_CPL*ROB_ENTRY_W-1:0] cpl_idx,
  input  logic                           retire_en,
  input  rob_idx_t                       retire_idx,
  input  logic                           flush,
  input  rob_idx_t                       head_idx,
  output logic                           head_valid,
  output logic                           head_done,
  output rob_payload_t                   head_data,
  output logic [ROB_DEPTH-1:0]           valid_bits
);

  logic [ROB_DEPTH-1:0] valid_q;
  logic [ROB_DEPTH-1:0] done_q;
  rob_payload_t         payload_q [ROB_DEPTH];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      // completions only land on live entries; stale indices are dropped
      for (int p = 0; p < NUM_CPL; p++) begin
        if (cpl_en[p] && valid_q[cpl_slice(cpl_idx, p)])
          done_q[cpl_slice(cpl_idx, p)] <= 1'b1;
      end
      if (retire_en) begin
        valid_q[retire_idx] <= 1'b0;
        done_q[retire_idx]  <= 1'b0;
      end
      if (alloc_en) begin
        valid_q[alloc_idx] <= 1'b1;
        done_q[alloc_idx]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_en)
      payload_q[alloc_idx] <= alloc_data;
  end

  assign head_valid = valid_q[head_idx];
  assign head_done  = done_q[head_idx];
  assign head_data  = payload_q[head_idx];
  assign valid_bits = valid_q;

endmodule

// File: rtl/rob_completion_unit.sv
// Reorder buffer terminating the completion interface: in-order commit, redirect+flush on terminators.
// Optional ROB_PERF_CNT_EN adds perf_commits / perf_full_stalls counters.
module rob_completion_unit
  import rob_completion_unit_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alloc_valid,
  output logic                           alloc_ready,
  input  logic [2*ARCH_W-1:0]            alloc_arch_dests,
  input  logic [2*PR_ADDR_W-1:0]         alloc_phys_dests,
  input  logic                           alloc_is_term,
  output logic [ROB_ENTRY_W-1:0]         alloc_entry,
  input  logic [NUM_CPL*ROB_ENTRY_W-1:0] ROB_entries_in,
  input  logic                           complete_arith_valid,
  input  logic                           complete_mem_valid,
  input  logic                           complete_term_valid,
  output logic                           complete_term_ready,
  input  logic [15:0]                    term_address,
  output logic                           commit_valid,
  output logic [2*ARCH_W-1:0]            commit_arch_dests,
  output logic [2*PR_ADDR_W-1:0]         commit_phys_dests,
  output logic                           redirect_valid,
  output logic [15:0]                    redirect_addr,
  output logic                           rob_empty
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_commits,
  output logic [31:0]                    perf_full_stalls
`endif
);

  rob_idx_t             head_q;
  rob_idx_t             tail_q;
  logic [ROB_ENTRY_W:0] count_q;
  logic                 term_pending_q;
  logic [15:0]          term_addr_q;
  rob_idx_t             term_entry_q;

  logic                 head_valid;
  logic                 head_done;
  rob_payload_t         head_data;
  logic [ROB_DEPTH-1:0] valid_bits;

  logic                 commit_fire;
  logic                 term_commit;
  logic                 alloc_fire;
  logic                 term_accept;
  rob_idx_t             term_idx;
  rob_payload_t         alloc_data;
  logic [NUM_CPL-1:0]   cpl_en;

  assign commit_fire = head_valid && head_done;
  assign term_commit = commit_fire && head_data.is_term;
  // a committing terminator flushes the tail, so no allocation may race it
  assign alloc_ready = (count_q != FULL_COUNT) && !term_commit;
  assign alloc_fire  = alloc_valid && alloc_ready;

  assign complete_term_ready = !term_pending_q;
  assign term_accept         = complete_term_valid && complete_term_ready;
  assign term_idx            = cpl_slice(ROB_entries_in, CPL_TERM);

  assign alloc_entry = tail_q;
  assign rob_empty   = (count_q == '0);

  assign alloc_data = '{is_term:    alloc_is_term,
                        arch_dests: alloc_arch_dests,
                        phys_dests: alloc_phys_dests};

  always_comb begin
    cpl_en            = '0;
    cpl_en[CPL_ARITH] = complete_arith_valid;
    cpl_en[CPL_MEM]   = complete_mem_valid;
    cpl_en[CPL_TERM]  = term_accept;
  end

  rob_entry_array u_entries (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (alloc_fire),
    .alloc_idx  (tail_q),
    .alloc_data (alloc_data),
    .cpl_en     (cpl_en),
    .cpl_idx    (ROB_entries_in),
    .retire_en  (commit_fire && !term_commit),
    .retire_idx (head_q),
    .flush      (term_commit),
    .head_idx   (head_q),
    .head_valid (head_valid),
    .head_done  (head_done),
    .head_data  (head_data),
    .valid_bits (valid_bits)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      term_pending_q    <= 1'b0;
      term_addr_q       <= '0;
      term_entry_q      <= '0;
      commit_valid      <= 1'b0;
      commit_arch_dests <= '0;
      commit_phys_dests <= '0;
      redirect_valid    <= 1'b0;
      redirect_addr     <= '0;
    end else begin
      commit_valid   <= commit_fire;
      redirect_valid <= term_commit;
      if (commit_fire) begin
        commit_arch_dests <= head_data.arch_dests;
        commit_phys_dests <= head_data.phys_dests;
      end
      if (term_commit) begin
        redirect_addr  <= term_addr_q;
        head_q         <= head_q + 1'b1;
        tail_q         <= head_q + 1'b1;
        count_q        <= '0;
        term_pending_q <= 1'b0;
      end else begin
        if (commit_fire)
          head_q <= head_q + 1'b1;
        if (alloc_fire)
          tail_q <= tail_q + 1'b1;
        case ({alloc_fire, commit_fire})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
        // a non-terminator completed on the term port releases the slot when it retires
        if (commit_fire && term_pending_q && (head_q == term_entry_q))
          term_pending_q <= 1'b0;
        else if (term_accept && valid_bits[term_idx]) begin
          term_pending_q <= 1'b1;
          term_addr_q    <= term_address;
          term_entry_q   <= term_idx;
        end
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_commits     <= '0;
      perf_full_stalls <= '0;
    end else begin
      if (commit_valid)
        perf_commits <= perf_commits + 32'd1;
      if (alloc_valid && !alloc_ready)
        perf_full_stalls <= perf_full_stalls + 32'd1;
    end
  end
`endif

endmodule
